// File: rtl/etch_trace_engine_pkg.sv
// Shared types for the Etch-A-Sketch tile tracer: FSM states, tile word layout
// and the 8-entry 12-bit colour palette.
package etch_pkg;

    typedef enum logic {
        DRAW  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    typedef struct packed {
        logic       painted;
        logic [2:0] color;
    } tile_t;

    localparam tile_t TILE_BLANK = '0;

    function automatic logic [11:0] palette(input logic [2:0] idx);
        logic [11:0] c;
        case (idx)
            3'd0: c = 12'hFFF;
            3'd1: c = 12'hF00;
            3'd2: c = 12'h0F0;
            3'd3: c = 12'h00F;
            3'd4: c = 12'hFF0;
            3'd5: c = 12'h0FF;
            3'd6: c = 12'hF0F;
            3'd7: c = 12'h888;
            default: c = 12'h000;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/etch_trace_engine_tile_ram.sv
// Simple dual-port tile RAM: synchronous write, registered read (old data on
// same-address read/write collision).
module tile_ram
    import etch_pkg::*;
#(
    parameter int unsigned DEPTH = 2400,
    parameter int unsigned AW    = 12
) (
    input  logic          clk_100MHz,
    input  logic          reset_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  tile_t         wdata,
    input  logic [AW-1:0] raddr,
    output tile_t         rdata
);

    tile_t mem [DEPTH];

    always_ff @(posedge clk_100MHz) begin
        if (we)
            mem[waddr] <= wdata;
    end

    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n)
            rdata <= TILE_BLANK;
        else
            rdata <= mem[raddr];
    end

endmodule

// File: rtl/etch_trace_engine.sv
// Cursor tracer, clear-screen sweep and tile renderer for the VGA path.
// Optional cursor blink is compiled in with TRACE_CURSOR_BLINK_EN.
module etch_trace_engine
    import etch_pkg::*;
#(
    parameter int unsigned COLS        = 80,
    parameter int unsigned ROWS        = 30,
    parameter int unsigned TILE_W_LOG2 = 3,
    parameter int unsigned TILE_H_LOG2 = 4,
    parameter int unsigned WRAP        = 1,
    parameter int unsigned BLINK_HALF  = 25_000_000
) (
    input  logic                     clk_100MHz,
    input  logic                     reset_n,
    input  logic                     video_on,
    input  logic [9:0]               x,
    input  logic [9:0]               y,
    input  logic                     move_left,
    input  logic                     move_right,
    input  logic                     move_up,
    input  logic                     move_down,
    input  logic                     trace_en,
    input  logic [2:0]               color_sel,
    input  logic                     clear_req,
    output logic                     clear_busy,
    output logic [$clog2(COLS)-1:0]  cur_x,
    output logic [$clog2(ROWS)-1:0]  cur_y,
    output logic [3:0]               led,
    output logic [11:0]              rgb
);

    localparam int unsigned DEPTH = COLS * ROWS;
    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned CXW   = $clog2(COLS);
    localparam int unsigned CYW   = $clog2(ROWS);

    state_t         state, state_nxt;
    logic [AW-1:0]  sweep, sweep_nxt;
    logic [CXW-1:0] cx_nxt, cx_mv;
    logic [CYW-1:0] cy_nxt, cy_mv;
    logic [3:0]     led_nxt;
    logic           x_inc, x_dec, y_up, y_down, x_moved, y_moved;
    logic           we;
    logic [AW-1:0]  waddr, paint_addr;
    tile_t          wdata;

    assign x_inc  = move_right & ~move_left;
    assign x_dec  = move_left  & ~move_right;
    assign y_up   = move_up    & ~move_down;
    assign y_down = move_down  & ~move_up;

    // A saturated move leaves the position alone and does not count as a move.
    always_comb begin
        cx_mv   = cur_x;
        x_moved = 1'b0;
        if (x_inc) begin
            if (32'(cur_x) == COLS - 1) begin
                if (WRAP != 0) begin
                    cx_mv   = '0;
                    x_moved = 1'b1;
                end
            end else begin
                cx_mv   = cur_x + 1'b1;
                x_moved = 1'b1;
            end
        end else if (x_dec) begin
            if (cur_x == '0) begin
                if (WRAP != 0) begin
                    cx_mv   = CXW'(COLS - 1);
                    x_moved = 1'b1;
                end
            end else begin
                cx_mv   = cur_x - 1'b1;
                x_moved = 1'b1;
            end
        end
    end

    always_comb begin
        cy_mv   = cur_y;
        y_moved = 1'b0;
        if (y_down) begin
            if (32'(cur_y) == ROWS - 1) begin
                if (WRAP != 0) begin
                    cy_mv   = '0;
                    y_moved = 1'b1;
                end
            end else begin
                cy_mv   = cur_y + 1'b1;
                y_moved = 1'b1;
            end
        end else if (y_up) begin
            if (cur_y == '0) begin
                if (WRAP != 0) begin
                    cy_mv   = CYW'(ROWS - 1);
                    y_moved = 1'b1;
                end
            end else begin
                cy_mv   = cur_y - 1'b1;
                y_moved = 1'b1;
            end
        end
    end

    assign paint_addr = AW'(32'(cur_y) * COLS + 32'(cur_x));

    always_comb begin
        state_nxt = state;
        sweep_nxt = sweep;
        cx_nxt    = cur_x;
        cy_nxt    = cur_y;
        led_nxt   = led;
        we        = 1'b0;
        waddr     = paint_addr;
        wdata     = '{painted: 1'b1, color: color_sel};
        case (state)
            DRAW: begin
                we = trace_en;
                if (clear_req) begin
                    state_nxt = CLEAR;
                    sweep_nxt = '0;
                    cx_nxt    = '0;
                    cy_nxt    = '0;
                end else begin
                    cx_nxt = cx_mv;
                    cy_nxt = cy_mv;
                    if (x_moved)
                        led_nxt = x_inc ? 4'b0100 : 4'b1000;
                    else if (y_moved)
                        led_nxt = y_up ? 4'b0010 : 4'b0001;
                end
            end
            CLEAR: begin
                we        = 1'b1;
                waddr     = sweep;
                wdata     = TILE_BLANK;
                sweep_nxt = sweep + 1'b1;
                if (32'(sweep) == DEPTH - 1)
                    state_nxt = DRAW;
            end
            default: state_nxt = DRAW;
        endcase
    end

    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            state <= DRAW;
            sweep <= '0;
            cur_x <= '0;
            cur_y <= '0;
            led   <= '0;
        end else begin
            state <= state_nxt;
            sweep <= sweep_nxt;
            cur_x <= cx_nxt;
            cur_y <= cy_nxt;
            led   <= led_nxt;
        end
    end

    assign clear_busy = (state == CLEAR);

    // Render: stage 1 is the RAM read plus tile coordinate delay, stage 2 the rgb register.
    logic [9:0]    col, row, col_d1, row_d1;
    logic          in_map, in_map_d1, vid_d1, is_cursor, blink_on;
    logic [AW-1:0] raddr;
    tile_t         ram_q;
    logic [11:0]   pix;

    assign col    = x >> TILE_W_LOG2;
    assign row    = y >> TILE_H_LOG2;
    assign in_map = (32'(col) < COLS) && (32'(row) < ROWS);
    assign raddr  = in_map ? AW'(32'(row) * COLS + 32'(col)) : '0;

    tile_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_tile_ram (
        .clk_100MHz (clk_100MHz),
        .reset_n    (reset_n),
        .we         (we),
        .waddr      (waddr),
        .wdata      (wdata),
        .raddr      (raddr),
        .rdata      (ram_q)
    );

`ifdef TRACE_CURSOR_BLINK_EN
    logic [31:0] blink_cnt;
    logic        blink_phase;

    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b1;
        end else if (blink_cnt == 32'(BLINK_HALF - 1)) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end

    assign blink_on = blink_phase;
`else
    assign blink_on = 1'b1;
`endif

    assign is_cursor = (32'(col_d1) == 32'(cur_x)) && (32'(row_d1) == 32'(cur_y));

    always_comb begin
        pix = ram_q.painted ? palette(ram_q.color) : 12'h000;
        if (is_cursor && blink_on)
            pix = ~pix;
    end

    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            col_d1    <= '0;
            row_d1    <= '0;
            in_map_d1 <= 1'b0;
            vid_d1    <= 1'b0;
            rgb       <= '0;
        end else begin
            col_d1    <= col;
            row_d1    <= row;
            in_map_d1 <= in_map;
            vid_d1    <= video_on;
            rgb       <= (vid_d1 && in_map_d1) ? pix : 12'h000;
        end
    end

endmodule

// File: tb/tb_etch_trace_engine.sv
// Directed bench for etch_trace_engine: cursor moves/wrap/saturation, painting
// and rendering, clear sweep, and reset during a sweep.
module tb_etch_trace_engine;

    logic       clk_100MHz = 1'b0;
    logic       reset_n;
    logic       video_on;
    logic [9:0] x, y;
    logic       move_left, move_right, move_up, move_down;
    logic       trace_en;
    logic [2:0] color_sel;
    logic       clear_req;

    logic       busy_w, busy_s;
    logic [6:0] cx_w, cx_s;
    logic [4:0] cy_w, cy_s;
    logic [3:0] led_w, led_s;
    logic [11:0] rgb_w, rgb_s;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk_100MHz = ~clk_100MHz;

    etch_trace_engine #(.COLS(80), .ROWS(30), .WRAP(1)) u_dut (
        .clk_100MHz (clk_100MHz), .reset_n (reset_n), .video_on (video_on),
        .x (x), .y (y), .move_left (move_left), .move_right (move_right),
        .move_up (move_up), .move_down (move_down), .trace_en (trace_en),
        .color_sel (color_sel), .clear_req (clear_req), .clear_busy (busy_w),
        .cur_x (cx_w), .cur_y (cy_w), .led (led_w), .rgb (rgb_w)
    );

    etch_trace_engine #(.COLS(80), .ROWS(30), .WRAP(0)) u_sat (
        .clk_100MHz (clk_100MHz), .reset_n (reset_n), .video_on (video_on),
        .x (x), .y (y), .move_left (move_left), .move_right (move_right),
        .move_up (move_up), .move_down (move_down), .trace_en (trace_en),
        .color_sel (color_sel), .clear_req (clear_req), .clear_busy (busy_s),
        .cur_x (cx_s), .cur_y (cy_s), .led (led_s), .rgb (rgb_s)
    );

    typedef struct {
        logic [9:0]  px;
        logic [9:0]  py;
        logic        vid;
        logic [11:0] exp_rgb;
    } vec_t;

    vec_t vecs [11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_100MHz);
        #1;
    endtask

    task automatic render(input string name, input logic [9:0] px, input logic [9:0] py,
                          input logic vid, input logic [11:0] exp);
        x = px;
        y = py;
        video_on = vid;
        tick();
        tick();
        check(name, 32'(rgb_w), 32'(exp));
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (3) @(posedge clk_100MHz);
        #1 reset_n = 1'b1;
        tick();
    endtask

    initial begin
        int cnt;
        reset_n = 1'b0;
        video_on = 1'b0; x = '0; y = '0;
        move_left = 0; move_right = 0; move_up = 0; move_down = 0;
        trace_en = 0; color_sel = '0; clear_req = 0;

        vecs[0]  = '{10'd0,   10'd0,   1'b1, 12'hF00};
        vecs[1]  = '{10'd8,   10'd0,   1'b1, 12'hF00};
        vecs[2]  = '{10'd16,  10'd0,   1'b1, 12'hF00};
        vecs[3]  = '{10'd24,  10'd0,   1'b1, 12'h0FF};
        vecs[4]  = '{10'd31,  10'd15,  1'b1, 12'h0FF};
        vecs[5]  = '{10'd32,  10'd0,   1'b1, 12'h000};
        vecs[6]  = '{10'd0,   10'd16,  1'b1, 12'h000};
        vecs[7]  = '{10'd8,   10'd0,   1'b0, 12'h000};
        vecs[8]  = '{10'd640, 10'd0,   1'b1, 12'h000};
        vecs[9]  = '{10'd0,   10'd480, 1'b1, 12'h000};
        vecs[10] = '{10'd639, 10'd479, 1'b1, 12'h000};

        repeat (3) @(posedge clk_100MHz);
        #1;
        check("reset_busy", 32'(busy_w), 0);
        check("reset_cur_x", 32'(cx_w), 0);
        check("reset_cur_y", 32'(cy_w), 0);
        check("reset_led", 32'(led_w), 0);
        check("reset_rgb", 32'(rgb_w), 0);
        reset_n = 1'b1;
        tick();

        // Edge behaviour: wrap instance vs saturating instance
        move_left = 1; tick(); move_left = 0;
        check("wrap_left_cur_x", 32'(cx_w), 79);
        check("wrap_left_led", 32'(led_w), 32'b1000);
        check("sat_left_cur_x", 32'(cx_s), 0);
        check("sat_left_led", 32'(led_s), 0);
        move_right = 1; tick(); move_right = 0;
        check("wrap_right_cur_x", 32'(cx_w), 0);
        check("sat_right_cur_x", 32'(cx_s), 1);
        check("sat_right_led", 32'(led_s), 32'b0100);

        // Opposing Y ticks cancel; simultaneous X still applies
        move_up = 1; move_down = 1; move_right = 1; tick();
        move_up = 0; move_down = 0; move_right = 0;
        check("cancel_y_cur_y", 32'(cy_w), 0);
        check("cancel_y_cur_x", 32'(cx_w), 1);
        check("cancel_y_led", 32'(led_w), 32'b0100);
        move_up = 1; move_down = 1; tick(); move_up = 0; move_down = 0;
        check("cancel_only_cur_y", 32'(cy_w), 0);
        check("cancel_only_led", 32'(led_w), 32'b0100);
        move_up = 1; tick(); move_up = 0;
        check("wrap_up_cur_y", 32'(cy_w), 29);
        check("wrap_up_led", 32'(led_w), 32'b0010);
        check("sat_up_cur_y", 32'(cy_s), 0);
        check("sat_up_led", 32'(led_s), 32'b0100);
        move_right = 1; move_down = 1; tick(); move_right = 0; move_down = 0;
        check("xy_cur_x", 32'(cx_w), 2);
        check("xy_cur_y", 32'(cy_w), 0);
        check("xy_led_x_priority", 32'(led_w), 32'b0100);

        // Paint red along row 0 while moving right three times
        do_reset();
        color_sel = 3'd1; trace_en = 1;
        move_right = 1; tick(); tick(); tick(); move_right = 0;
        tick();
        trace_en = 0;
        check("paint_cur_x", 32'(cx_w), 3);
        for (int i = 0; i < 11; i++)
            render($sformatf("render_vec%0d", i), vecs[i].px, vecs[i].py, vecs[i].vid, vecs[i].exp_rgb);

        // Green tile at (3,29), then a full clear sweep
        color_sel = 3'd2;
        move_up = 1; tick(); move_up = 0;
        trace_en = 1; tick(); trace_en = 0;
        render("green_cursor", 10'd24, 10'd464, 1'b1, 12'hF0F);

        clear_req = 1; tick(); clear_req = 0;
        check("clear_busy_rise", 32'(busy_w), 1);
        check("clear_home_x", 32'(cx_w), 0);
        check("clear_home_y", 32'(cy_w), 0);
        cnt = 1;
        for (int i = 0; i < 5000; i++) begin
            if (cnt == 10) move_right = 1;
            tick();
            move_right = 0;
            if (!busy_w) break;
            cnt++;
        end
        check("clear_busy_cycles", 32'(cnt), 2400);
        check("clear_move_ignored_x", 32'(cx_w), 0);
        for (int r = 0; r < 30; r++)
            for (int c = 0; c < 80; c++)
                render($sformatf("cleared_%0d_%0d", c, r), 10'(c * 8), 10'(r * 16), 1'b1,
                       (r == 0 && c == 0) ? 12'hFFF : 12'h000);

        // Reset in the middle of a sweep leaves the upper addresses intact
        color_sel = 3'd1; trace_en = 1; tick(); trace_en = 0;
        move_up = 1; tick(); move_up = 0;
        move_right = 1; tick(); tick(); tick(); move_right = 0;
        color_sel = 3'd2; trace_en = 1; tick(); trace_en = 0;
        check("pre_sweep_cur_x", 32'(cx_w), 3);
        check("pre_sweep_cur_y", 32'(cy_w), 29);
        clear_req = 1; tick(); clear_req = 0;
        repeat (1000) tick();
        check("mid_sweep_busy", 32'(busy_w), 1);
        reset_n = 1'b0;
        #2;
        check("mid_reset_busy", 32'(busy_w), 0);
        @(posedge clk_100MHz);
        #1 reset_n = 1'b1;
        tick();
        check("post_reset_busy", 32'(busy_w), 0);
        check("post_reset_cur_x", 32'(cx_w), 0);
        render("partial_high_kept", 10'd24, 10'd464, 1'b1, 12'h0F0);
        render("partial_low_cleared", 10'd0, 10'd0, 1'b1, 12'hFFF);
        tick();
        check("still_draw", 32'(busy_w), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
